// File: rtl/step_decoder_pkg.sv
// Shared definitions for the step decoder.
//   mode_e      : operating mode of the decoder (direct decode or stepping sequence)
//   MAX_SEL_W   : widest supported select/index width
//   MAX_OUT_W   : one-hot width matching MAX_SEL_W
//   onehot()    : select value to one-hot vector at the maximum width; callers
//                 cast the result down to their own output width
package step_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SEQ    = 1'b1
  } mode_e;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_OUT_W = 64;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_OUT_W-1:0] vec;
    vec      = {MAX_OUT_W{1'b0}};
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage : step_decoder_pkg

// File: rtl/step_decoder_onehot.sv
// Combinational select-to-one-hot decode with enable.
//   sel_i    [SEL_W-1:0] : select value
//   en_i                 : when low the output is all zeros
//   onehot_o [OUT_W-1:0] : one-hot vector with bit sel_i set
module step_decoder_onehot
  import step_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] onehot_o
);

  // Decode the select, blanking the whole vector when disabled.
  always_comb begin
    onehot_o = {OUT_W{1'b0}};
    if (en_i) begin
      onehot_o = OUT_W'(onehot(MAX_SEL_W'(sel_i)));
    end else begin
      onehot_o = {OUT_W{1'b0}};
    end
  end

endmodule : step_decoder_onehot

// File: rtl/step_decoder.sv
// Registered one-hot step decoder.
// In direct mode the index follows In; in sequence mode it is loaded from In
// or stepped by one, wrapping to zero after Last. Out is the one-hot of the
// index being registered on the same edge, so Index and Out always agree.
//   Clk, Rst_n            : clock and asynchronous active-low reset
//   En                    : enable; low holds the index and blanks Out
//   Mode                  : 0 direct decode of In, 1 stepping sequence
//   Clr                   : synchronous clear to RST_IDX (works with En low)
//   Load, Step            : sequence-mode load from In / advance by one
//   In   [SEL_W-1:0]      : select or load value
//   Last [SEL_W-1:0]      : terminal index of the sequence
//   Out  [OUT_W-1:0]      : registered one-hot strobe
//   Index[SEL_W-1:0]      : current index register
//   Wrap                  : one-cycle pulse on the edge that wraps Last -> 0
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 2**SEL_W,
  parameter int RST_IDX = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             Mode,
  input  logic             Clr,
  input  logic             Load,
  input  logic             Step,
  input  logic [SEL_W-1:0] In,
  input  logic [SEL_W-1:0] Last,
  output logic [OUT_W-1:0] Out,
  output logic [SEL_W-1:0] Index,
  output logic             Wrap
);

  localparam logic [SEL_W-1:0] RST_VAL = SEL_W'(RST_IDX);

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic             wrap_q;
  logic             wrap_d;

  // Next index and wrap pulse, in priority order Clr > hold > direct > Load > Step.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (Clr) begin
      idx_d = RST_VAL;
    end else if (!En) begin
      idx_d = idx_q;
    end else if (Mode == MODE_DIRECT) begin
      idx_d = In;
    end else if (Load) begin
      idx_d = In;
    end else if (Step) begin
      // ">=" so that an index loaded beyond Last still wraps on its next step.
      if (idx_q >= Last) begin
        idx_d  = {SEL_W{1'b0}};
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Out is decoded from the next index so it lines up with Index after the edge.
  step_decoder_onehot #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_onehot (
    .sel_i    (idx_d),
    .en_i     (En),
    .onehot_o (out_d)
  );

  // State registers: index, one-hot strobe and wrap pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idx_q  <= RST_VAL;
      out_q  <= {OUT_W{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign Index = idx_q;
  assign Out   = out_q;
  assign Wrap  = wrap_q;

endmodule : step_decoder

// File: doc/step_decoder.md
STEP_DECODER -- requirements
Module: step_decoder

Interface
REQ-001 Parameter SEL_W, default 3, select/index width in bits (1..6).
REQ-002 Parameter OUT_W, default 2**SEL_W, one-hot output width; derived, never overridden.
REQ-003 Parameter RST_IDX, default 0, index value loaded at reset and by Clr.
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Rst_n  input  1  asynchronous active-low reset.
REQ-006 En  input  1  active-high enable; low freezes index and blanks Out.
REQ-007 Mode  input  1  0 = direct (registered decode of In), 1 = sequence (stepping counter).
REQ-008 Clr  input  1  synchronous clear of index to RST_IDX.
REQ-009 Load  input  1  load index from In (sequence mode).
REQ-010 Step  input  1  advance index by one (sequence mode).
REQ-011 In  input  SEL_W  select value / load value.
REQ-012 Last  input  SEL_W  terminal index; sequence wraps after Last.
REQ-013 Out  output  OUT_W  registered one-hot strobe, all-zero when disabled.
REQ-014 Index  output  SEL_W  current internal index register.
REQ-015 Wrap  output  1  registered one-cycle pulse on Last->0 transition.

Function
REQ-016 Next-index priority per edge: Clr > En low (hold) > Mode 0 (idx_n = In) > Load (idx_n = In) > Step (wrap rule) > hold.
REQ-017 Step wrap rule: idx_n = 0 when idx >= Last, else idx + 1; arithmetic modulo 2**SEL_W, no carry out.
REQ-018 Clr applies even when En is low; Wrap = 0 on that edge.
REQ-019 Out register: Out <= En ? onehot(idx_n) : 0, i.e. Out shows the new index in the same cycle Index does; exactly one bit set whenever En was high at the last edge.
REQ-020 Latency: In change (Mode 0) or Load/Step (Mode 1) visible on Index and Out after exactly one rising edge.
REQ-021 Wrap <= 1 only on an edge where Step causes idx >= Last -> 0 with Mode 1, En 1, Clr 0, Load 0; else 0.
REQ-022 Load and Step together: Load wins, Wrap = 0.
REQ-023 Load of In > Last allowed; next Step from there wraps to 0 with Wrap pulse.
REQ-024 Last = 0: every Step yields idx 0 with Wrap pulse each cycle.
REQ-025 Mode switch 1->0 mid-sequence: next edge idx = In; 0->1: sequence resumes from current idx.
REQ-026 En low->high with no Load/Step: Out re-asserts onehot(held idx) after one edge.

Reset
REQ-027 Rst_n low asynchronously forces Index = RST_IDX, Out = 0, Wrap = 0, regardless of Clk.
REQ-028 Rst_n deassertion takes effect at next rising edge; Out stays 0 until first edge with En high.
REQ-029 Reset asserted mid-sequence discards index; no Wrap pulse generated by reset.

Structure
REQ-030 Shared package holds MODE_DIRECT = 0, MODE_SEQ = 1 constants and the onehot function (SEL_W -> OUT_W).
REQ-031 One sub-module, step_decoder_onehot: purely combinational SEL_W-to-OUT_W decode with enable, reused for Out next-state.
REQ-032 Only Index, Out and Wrap are registers; no other state.

Verification
REQ-033 Reset: Rst_n 0 mid-clock with Index 5 -> Index 0, Out 0x00, Wrap 0 immediately, before next edge.
REQ-034 Direct: SEL_W 3, Mode 0, En 1, In 0..7 one per cycle -> Out 0x01,0x02,...,0x80 each one edge after In.
REQ-035 Sequence wrap: Mode 1, Last 4, Step held 1 from idx 0 -> Index 1,2,3,4,0,1; Wrap 1 only on the edge giving 0.
REQ-036 Priority: idx 2, Load 1, Step 1, In 6 -> Index 6, Out 0x40, Wrap 0; then Step with Last 4 -> Index 0, Wrap 1.
REQ-037 Enable: En 0 with Step 1 for 3 cycles at idx 3 -> Index 3, Out 0x00; En 1 -> Out 0x08 next edge; Clr with En 0 -> Index 0.
REQ-038 Width: SEL_W 4, Last 15, 16 Steps from 0 -> Out walks 0x0001..0x8000, single Wrap pulse, back to 0x0001.
